// File: rtl/sdcard_pm_policy.sv
// SD card power-management policy: turns software requests, activity and wake events
// into power controller commands. Optional statistics counters: define SDCARD_PM_STATS_EN.
module sdcard_pm_policy #(
    parameter int IDLE_TIMEOUT  = 1024,
    parameter int SLEEP_TIMEOUT = 65536,
    parameter int WAKE_TIMEOUT  = 4096,
    parameter int CNT_W         = 20
) (
    input  logic       PCLK_i,
    input  logic       PRESETn_i,
    input  logic       pm_enable_i,
    input  logic       sw_req_valid_i,
    input  logic [1:0] sw_req_state_i,
    input  logic       volt_req_valid_i,
    input  logic [3:0] volt_req_i,
    input  logic       activity_i,
    input  logic       wake_req_i,
    input  logic       power_good_i,
    input  logic       power_fault_i,
    input  logic       fault_clear_i,
    output logic [1:0] power_state_o,
    output logic [3:0] voltage_sel_o,
    output logic       clk_enable_o,
    output logic       pm_busy_o,
    output logic       pm_irq_o,
    output logic       fault_sticky_o
`ifdef SDCARD_PM_STATS_EN
    ,
    output logic [15:0] stat_wake_cnt_o,
    output logic [15:0] stat_fault_cnt_o
`endif
);

    typedef enum logic [2:0] {
        ST_DOWN,
        ST_WAKE,
        ST_ACTIVE,
        ST_IDLE,
        ST_SLEEP,
        ST_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SLEEP_LAST = CNT_W'(SLEEP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             wake_ev;

    logic             pend_valid;
    logic [3:0]       pend_volt;
    logic             pend_valid_d;
    logic [3:0]       pend_volt_d;
    logic             hold_volt;
    logic             apply_pend;

    logic [1:0]       power_state_d;
    logic [3:0]       voltage_sel_d;
    logic             clk_enable_d;
    logic             pm_busy_d;
    logic             pm_irq_d;
    logic             fault_sticky_d;

    assign wake_ev = wake_req_i & pm_enable_i;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state <= ST_DOWN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
        end
    end

    // A fault outranks everything except in DOWN (nothing powered) and FAULT (only a clear exits).
    always_comb begin
        next_state = state;
        if (power_fault_i && (state != ST_DOWN) && (state != ST_FAULT)) begin
            next_state = ST_FAULT;
        end else begin
            unique case (state)
                ST_DOWN: begin
                    if (sw_req_valid_i) begin
                        if (sw_req_state_i != 2'b11) next_state = ST_WAKE;
                    end else if (wake_ev) begin
                        next_state = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (sw_req_valid_i && (sw_req_state_i == 2'b11)) next_state = ST_DOWN;
                    else if (power_good_i)                            next_state = ST_ACTIVE;
                    else if (cnt == WAKE_LAST)                        next_state = ST_FAULT;
                end
                ST_ACTIVE: begin
                    if (sw_req_valid_i) begin
                        unique case (sw_req_state_i)
                            2'b01:   next_state = ST_IDLE;
                            2'b10:   next_state = ST_SLEEP;
                            2'b11:   next_state = ST_DOWN;
                            default: next_state = ST_ACTIVE;
                        endcase
                    end else if (!activity_i && pm_enable_i && (cnt == IDLE_LAST)) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (sw_req_valid_i) begin
                        unique case (sw_req_state_i)
                            2'b00:   next_state = ST_ACTIVE;
                            2'b10:   next_state = ST_SLEEP;
                            2'b11:   next_state = ST_DOWN;
                            default: next_state = ST_IDLE;
                        endcase
                    end else if (activity_i || wake_ev) begin
                        next_state = ST_ACTIVE;
                    end else if (pm_enable_i && (cnt == SLEEP_LAST)) begin
                        next_state = ST_SLEEP;
                    end
                end
                ST_SLEEP: begin
                    // Sleep removes card power, so leaving it always re-checks power_good via WAKE.
                    if (sw_req_valid_i) begin
                        if (sw_req_state_i == 2'b11)     next_state = ST_DOWN;
                        else if (sw_req_state_i != 2'b10) next_state = ST_WAKE;
                    end else if (activity_i || wake_ev) begin
                        next_state = ST_WAKE;
                    end
                end
                ST_FAULT: begin
                    if (fault_clear_i) next_state = ST_DOWN;
                end
                default: next_state = ST_DOWN;
            endcase
        end
    end

    // One shared counter; it restarts on every state change so it never carries over.
    always_comb begin
        cnt_nxt = '0;
        if (next_state == state) begin
            unique case (state)
                ST_WAKE:   cnt_nxt = cnt_inc;
                ST_ACTIVE: cnt_nxt = (activity_i || sw_req_valid_i || !pm_enable_i) ? '0 : cnt_inc;
                ST_IDLE:   cnt_nxt = pm_enable_i ? cnt_inc : cnt;
                default:   cnt_nxt = '0;
            endcase
        end
    end

    assign hold_volt  = (state == ST_ACTIVE) || (state == ST_WAKE) || (state == ST_FAULT);
    assign apply_pend = hold_volt &&
                        ((next_state == ST_IDLE) || (next_state == ST_SLEEP) || (next_state == ST_DOWN));

    // Outputs are decoded from the next state and registered so they follow the trigger by one cycle.
    always_comb begin
        power_state_d = 2'b11;
        clk_enable_d  = 1'b0;
        pm_busy_d     = 1'b0;
        unique case (next_state)
            ST_WAKE:   begin power_state_d = 2'b00; pm_busy_d = 1'b1; end
            ST_ACTIVE: begin power_state_d = 2'b00; clk_enable_d = 1'b1; end
            ST_IDLE:   power_state_d = 2'b01;
            ST_SLEEP:  power_state_d = 2'b10;
            default:   power_state_d = 2'b11;
        endcase

        voltage_sel_d = voltage_sel_o;
        pend_valid_d  = pend_valid;
        pend_volt_d   = pend_volt;
        if (volt_req_valid_i) begin
            if (hold_volt) begin
                pend_valid_d = 1'b1;
                pend_volt_d  = volt_req_i;
            end else begin
                voltage_sel_d = volt_req_i;
            end
        end
        if (apply_pend) begin
            if (pend_valid_d) voltage_sel_d = pend_volt_d;
            pend_valid_d = 1'b0;
            pend_volt_d  = '0;
        end

        pm_irq_d       = (next_state == ST_FAULT) && (state != ST_FAULT);
        fault_sticky_d = pm_irq_d ? 1'b1 : (fault_clear_i ? 1'b0 : fault_sticky_o);
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            power_state_o  <= 2'b11;
            voltage_sel_o  <= '0;
            clk_enable_o   <= 1'b0;
            pm_busy_o      <= 1'b0;
            pm_irq_o       <= 1'b0;
            fault_sticky_o <= 1'b0;
            pend_valid     <= 1'b0;
            pend_volt      <= '0;
        end else begin
            power_state_o  <= power_state_d;
            voltage_sel_o  <= voltage_sel_d;
            clk_enable_o   <= clk_enable_d;
            pm_busy_o      <= pm_busy_d;
            pm_irq_o       <= pm_irq_d;
            fault_sticky_o <= fault_sticky_d;
            pend_valid     <= pend_valid_d;
            pend_volt      <= pend_volt_d;
        end
    end

`ifdef SDCARD_PM_STATS_EN
    logic wake_entry;
    assign wake_entry = (next_state == ST_WAKE) && ((state == ST_DOWN) || (state == ST_SLEEP));

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            stat_wake_cnt_o  <= '0;
            stat_fault_cnt_o <= '0;
        end else begin
            if (wake_entry && (stat_wake_cnt_o != 16'hFFFF)) stat_wake_cnt_o <= stat_wake_cnt_o + 16'd1;
            if (pm_irq_d && (stat_fault_cnt_o != 16'hFFFF))  stat_fault_cnt_o <= stat_fault_cnt_o + 16'd1;
        end
    end
`endif

endmodule
